memory_unit: RTL and testbench

//  Responder side of the 15-bit control word: MAR, memory data register (MDR) and 16x8 RAM.

---
 rtl/memory_unit_pkg.sv | 20 ++
 rtl/memory_unit_if.sv | 34 +++
 rtl/ram16x8.sv | 30 +++
 rtl/memory_unit.sv | 119 +++++++++++
 tb/tb_memory_unit.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/memory_unit_pkg.sv
// rtl/memory_unit_pkg.sv - shared types and constants for the memory unit
package memory_unit_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    // Bit positions of the memory controls inside the 15-bit control word.
    localparam int CW_WIDTH  = 15;
    localparam int SIG_L_MA  = 11;
    localparam int SIG_L_MD  = 10;
    localparam int SIG_CE    = 9;
    localparam int SIG_L_R   = 8;
    localparam logic [CW_WIDTH-1:0] CW_IDLE = 15'b000111111100011;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } mem_state_t;

endpackage

// File: rtl/memory_unit_if.sv
// rtl/memory_unit_if.sv - CPU control/bus and host program-load signals
// Ports: memory controls (active-low), shared bus in/out/oe, load_mode,
// prog_valid/ready/addr/data, prog_count, ctrl_err.
interface memory_unit_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  mar_addr_load_n;
    logic                  mar_mem_load_n;
    logic                  ram_en_n;
    logic                  ram_load_n;
    logic [DATA_WIDTH-1:0] bus_in;
    logic [DATA_WIDTH-1:0] bus_out;
    logic                  bus_oe;
    logic                  load_mode;
    logic                  prog_valid;
    logic [ADDR_WIDTH-1:0] prog_addr;
    logic [DATA_WIDTH-1:0] prog_data;
    logic                  prog_ready;
    logic [ADDR_WIDTH:0]   prog_count;
    logic                  ctrl_err;

    modport slave (
        input  mar_addr_load_n, mar_mem_load_n, ram_en_n, ram_load_n,
        input  bus_in, load_mode, prog_valid, prog_addr, prog_data,
        output bus_out, bus_oe, prog_ready, prog_count, ctrl_err
    );

    modport master (
        output mar_addr_load_n, mar_mem_load_n, ram_en_n, ram_load_n,
        output bus_in, load_mode, prog_valid, prog_addr, prog_data,
        input  bus_out, bus_oe, prog_ready, prog_count, ctrl_err
    );
endinterface

// File: rtl/ram16x8.sv
// rtl/ram16x8.sv - flop-array RAM, async clear, one write port, combinational read
// Ports: clk, resetn, we/waddr/wdata (write), raddr -> rdata (read).
module ram16x8 #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/memory_unit.sv
// rtl/memory_unit.sv - MAR, MDR and 16x8 RAM responder with host program-load port
// Ports: clk, resetn (async, active-low), mem (memory_unit_if.slave: CPU memory
// controls, shared bus, host load handshake, prog_count, ctrl_err).
module memory_unit
    import memory_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic          clk,
    input  logic          resetn,
    memory_unit_if.slave  mem
);
    localparam logic [ADDR_WIDTH:0] CNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

    mem_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] mar_q;
    logic [DATA_WIDTH-1:0] mdr_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  err_q;

    logic                  run;
    logic                  host_we;
    logic                  cpu_we;
    logic                  conflict;
    logic                  enter_load;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // The upper bus bits carry nothing for the MAR.
    logic [DATA_WIDTH-ADDR_WIDTH-1:0] unused_bus_hi;
    assign unused_bus_hi = mem.bus_in[DATA_WIDTH-1:ADDR_WIDTH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        run        = 1'b0;
        host_we    = 1'b0;
        cpu_we     = 1'b0;
        conflict   = 1'b0;
        enter_load = 1'b0;
        case (state_q)
            ST_RUN: begin
                run        = 1'b1;
                cpu_we     = ~mem.ram_load_n & mem.ram_en_n;
                conflict   = ~mem.ram_load_n & ~mem.ram_en_n;
                enter_load = mem.load_mode;
                if (mem.load_mode) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Dropping load_mode wins over a pending handshake.
                host_we = mem.load_mode & mem.prog_valid;
                if (!mem.load_mode) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Write-port mux: host and CPU writes are exclusive by state.
    assign ram_we    = host_we | cpu_we;
    assign ram_waddr = host_we ? mem.prog_addr : mar_q;
    assign ram_wdata = host_we ? mem.prog_data : mdr_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mar_q   <= '0;
            mdr_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (run && !mem.mar_addr_load_n) begin
                mar_q <= mem.bus_in[ADDR_WIDTH-1:0];
            end
            if (run && !mem.mar_mem_load_n) begin
                mdr_q <= mem.bus_in;
            end
            if (conflict) begin
                err_q <= 1'b1;
            end
            if (enter_load) begin
                count_q <= '0;
            end else if (host_we && count_q != CNT_MAX) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    ram16x8 #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk    (clk),
        .resetn (resetn),
        .we     (ram_we),
        .waddr  (ram_waddr),
        .wdata  (ram_wdata),
        .raddr  (mar_q),
        .rdata  (ram_rdata)
    );

    assign mem.bus_oe     = run & ~mem.ram_en_n;
    assign mem.bus_out    = mem.bus_oe ? ram_rdata : '0;
    assign mem.prog_ready = (state_q == ST_LOAD);
    assign mem.prog_count = count_q;
    assign mem.ctrl_err   = err_q;
endmodule

// File: tb/tb_memory_unit.sv
// tb/tb_memory_unit.sv - self-checking bench for memory_unit
module tb_memory_unit;
    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    memory_unit_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) mif ();

    memory_unit #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .mem    (mif)
    );

    int checks = 0;
    int passes = 0;

    // Reference model state
    bit [7:0] m_ram [16];
    bit [3:0] m_mar;
    bit [7:0] m_mdr;
    bit       m_load;
    int       m_cnt;
    bit       m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic m_reset();
        foreach (m_ram[i]) m_ram[i] = 8'h00;
        m_mar = 0; m_mdr = 0; m_load = 0; m_cnt = 0; m_err = 0;
    endtask

    task automatic ctl(input bit la, input bit lm, input bit ce, input bit lr, input bit [7:0] bus);
        mif.mar_addr_load_n = la;
        mif.mar_mem_load_n  = lm;
        mif.ram_en_n        = ce;
        mif.ram_load_n      = lr;
        mif.bus_in          = bus;
    endtask

    task automatic prog(input bit lm, input bit v, input bit [3:0] a, input bit [7:0] d);
        mif.load_mode  = lm;
        mif.prog_valid = v;
        mif.prog_addr  = a;
        mif.prog_data  = d;
    endtask

    // Called just after a negedge with inputs set: compare outputs to the model,
    // then advance model and DUT by one posedge.
    task automatic tick(input string tag);
        bit       oe;
        bit [3:0] n_mar;
        bit [7:0] n_mdr;
        #1;
        oe = !m_load && !mif.ram_en_n;
        chk({tag, "_oe"},    mif.bus_oe, oe);
        chk({tag, "_out"},   mif.bus_out, oe ? m_ram[m_mar] : 8'h00);
        chk({tag, "_rdy"},   mif.prog_ready, m_load);
        chk({tag, "_cnt"},   mif.prog_count, m_cnt);
        chk({tag, "_err"},   mif.ctrl_err, m_err);
        n_mar = m_mar;
        n_mdr = m_mdr;
        @(posedge clk);
        if (!m_load) begin
            if (!mif.ram_load_n) begin
                if (!mif.ram_en_n) m_err = 1;
                else m_ram[m_mar] = m_mdr;
            end
            if (!mif.mar_addr_load_n) n_mar = mif.bus_in[3:0];
            if (!mif.mar_mem_load_n) n_mdr = mif.bus_in;
            m_mar = n_mar;
            m_mdr = n_mdr;
            if (mif.load_mode) begin
                m_load = 1;
                m_cnt  = 0;
            end
        end else begin
            if (!mif.load_mode) m_load = 0;
            else if (mif.prog_valid) begin
                m_ram[mif.prog_addr] = mif.prog_data;
                if (m_cnt < 16) m_cnt++;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        resetn = 1'b0;
        ctl(1, 1, 1, 1, 8'h00);
        prog(0, 0, 4'h0, 8'h00);
        m_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_oe",  mif.bus_oe, 0);
        chk("rst_out", mif.bus_out, 0);
        chk("rst_rdy", mif.prog_ready, 0);
        chk("rst_cnt", mif.prog_count, 0);
        chk("rst_err", mif.ctrl_err, 0);
        @(negedge clk);
        resetn = 1'b1;

        // 1: host load, then CPU read of addr 14
        prog(1, 0, 0, 0);        tick("t1_enter");
        prog(1, 1, 4'h0, 8'h4E); tick("t1_w0");
        prog(1, 1, 4'hE, 8'h28); tick("t1_w14");
        prog(1, 0, 0, 0);
        #1 chk("t1_count", mif.prog_count, 2);
        tick("t1_hold");
        prog(0, 0, 0, 0);        tick("t1_exit");
        ctl(0, 1, 1, 1, 8'h0E);  tick("t1_mar");
        ctl(1, 1, 0, 1, 8'h00);
        #1 chk("t1_oe", mif.bus_oe, 1);
        chk("t1_read", mif.bus_out, 8'h28);
        tick("t1_rd");

        // 2: STA sequence
        ctl(0, 1, 1, 1, 8'h0F);  tick("t2_mar");
        ctl(1, 0, 1, 1, 8'hA5);  tick("t2_mdr");
        ctl(1, 1, 1, 0, 8'h00);  tick("t2_wr");
        ctl(1, 1, 0, 1, 8'h00);
        #1 chk("t2_read", mif.bus_out, 8'hA5);
        tick("t2_rd");

        // 3: CE and L_R together
        ctl(0, 1, 1, 1, 8'h03);  tick("t3_mar");
        ctl(1, 0, 1, 1, 8'h22);  tick("t3_mdr1");
        ctl(1, 1, 1, 0, 8'h00);  tick("t3_wr");
        ctl(1, 0, 1, 1, 8'h11);  tick("t3_mdr2");
        ctl(1, 1, 0, 0, 8'h00);  tick("t3_conf");
        ctl(1, 1, 0, 1, 8'h00);
        #1 chk("t3_err", mif.ctrl_err, 1);
        chk("t3_ram", mif.bus_out, 8'h22);
        tick("t3_rd");
        ctl(1, 1, 1, 1, 8'h00);
        repeat (3) tick("t3_idle");
        #1 chk("t3_sticky", mif.ctrl_err, 1);

        // 4: controls ignored in LOAD, count saturates
        prog(1, 0, 0, 0);        tick("t4_enter");
        for (int i = 0; i < 6; i++) begin
            ctl(i[0], i[1], i[0] ^ i[1], ~i[0], 8'h33);
            #1 chk("t4_iso_oe", mif.bus_oe, 0);
            tick("t4_iso");
        end
        ctl(1, 1, 1, 1, 8'h00);
        for (int i = 0; i < 17; i++) begin
            prog(1, 1, 4'($urandom_range(0, 15)), 8'($urandom));
            tick("t4_w");
        end
        prog(1, 0, 0, 0);
        #1 chk("t4_sat", mif.prog_count, 16);
        tick("t4_hold");
        prog(0, 0, 0, 0);        tick("t4_exit");
        ctl(1, 1, 0, 1, 8'h00);  tick("t4_mar_rd");
        ctl(1, 1, 1, 0, 8'h00);  tick("t4_wr_mdr");
        ctl(1, 1, 0, 1, 8'h00);
        #1 chk("t4_mdr", mif.bus_out, 8'h11);
        tick("t4_rd");

        // 5: async reset mid-cycle in LOAD with a pending write
        ctl(1, 1, 1, 1, 8'h00);
        prog(1, 0, 0, 0);        tick("t5_enter");
        prog(1, 1, 4'h7, 8'h99);
        #2 resetn = 1'b0;
        m_reset();
        #1 chk("t5_rdy", mif.prog_ready, 0);
        chk("t5_cnt", mif.prog_count, 0);
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        prog(0, 0, 0, 0);
        for (int a = 0; a < 16; a++) begin
            ctl(0, 1, 1, 1, 8'(a));  tick("t5_mar");
            ctl(1, 1, 0, 1, 8'h00);
            #1 chk("t5_zero", mif.bus_out, 8'h00);
            tick("t5_rd");
        end

        // 6: handshake on the LOAD exit edge is dropped
        ctl(1, 1, 1, 1, 8'h00);
        prog(1, 0, 0, 0);        tick("t6_enter");
        prog(0, 1, 4'h5, 8'h77); tick("t6_exit");
        prog(0, 0, 0, 0);
        #1 chk("t6_run", mif.prog_ready, 0);
        chk("t6_cnt", mif.prog_count, 0);
        tick("t6_idle");
        ctl(0, 1, 1, 1, 8'h05);  tick("t6_mar");
        ctl(1, 1, 0, 1, 8'h00);
        #1 chk("t6_nowr", mif.bus_out, 8'h00);
        tick("t6_rd");

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            ctl($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, 8'($urandom));
            prog(m_load ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 15) == 0),
                 $urandom_range(0, 1) != 0, 4'($urandom), 8'($urandom));
            tick("rnd");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
